// File: rtl/riscv_exu_dispatch_if.sv
// Decoder/execution-unit bundle for riscv_exu_dispatch.
// master : decoder + execution units + redirect source (drives ops, ready/done/wb, flush)
// slave  : the dispatch stage (drives hold, issue_vld, register_locked, busy)
interface riscv_exu_dispatch_if #(
    parameter int unsigned NUM_UNITS = 2
);
    logic                       in_vld;
    logic [NUM_UNITS-1:0]       in_unit;
    logic [4:0]                 in_rd;
    logic                       in_rd_used;
    logic [4:0]                 in_rs1;
    logic                       in_rs1_used;
    logic [4:0]                 in_rs2;
    logic                       in_rs2_used;
    logic                       hold;
    logic [NUM_UNITS-1:0]       issue_vld;
    logic [NUM_UNITS-1:0]       unit_ready;
    logic [NUM_UNITS-1:0]       unit_done;
    logic [NUM_UNITS-1:0]       wb_en;
    logic [NUM_UNITS-1:0][4:0]  wb_rd;
    logic                       flush;
    logic [31:0]                register_locked;
    logic                       busy;

    modport master (
        output in_vld, in_unit, in_rd, in_rd_used, in_rs1, in_rs1_used,
               in_rs2, in_rs2_used, unit_ready, unit_done, wb_en, wb_rd, flush,
        input  hold, issue_vld, register_locked, busy
    );

    modport slave (
        input  in_vld, in_unit, in_rd, in_rd_used, in_rs1, in_rs1_used,
               in_rs2, in_rs2_used, unit_ready, unit_done, wb_en, wb_rd, flush,
        output hold, issue_vld, register_locked, busy
    );
endinterface

// File: rtl/riscv_exu_dispatch.sv
// Issue/dispatch stage: steers decoded ops to one of NUM_UNITS execution units,
// interlocks RAW/WAW hazards through a register scoreboard, limits per-unit
// in-flight ops to UNIT_DEPTH and drains all units after a flush.
// Ports: clock, reset (async, active-high), bus (riscv_exu_dispatch_if.slave).
// Optional macro RISCV_EXU_DISPATCH_BYPASS_EN: same-cycle write-back clears and
// unit_done credits are visible to the issue check.
module riscv_exu_dispatch #(
    parameter int unsigned NUM_UNITS  = 2,
    parameter int unsigned UNIT_DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    riscv_exu_dispatch_if.slave    bus
);
    localparam int unsigned CNT_W  = $clog2(UNIT_DEPTH + 1);
    localparam int unsigned UIDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_e;

    state_e                         state_q, state_d;
    logic [31:0]                    locked_q, locked_d;
    logic [NUM_UNITS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [UIDX_W-1:0]              unit_idx;
    logic [31:0]                    clr_mask;
    logic [31:0]                    set_mask;
    logic [31:0]                    lock_view;
    logic                           credit_ok;
    logic                           hazard;
    logic                           issue_ok;
    logic                           all_idle;

    // Target unit decode; zero or multi-hot falls back to unit 0
    always_comb begin
        unit_idx = '0;
        if ($onehot(bus.in_unit)) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (bus.in_unit[k]) unit_idx = UIDX_W'(k);
            end
        end
    end

    // Registers released by write-back this cycle
    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (bus.wb_en[k]) clr_mask[bus.wb_rd[k]] = 1'b1;
        end
    end

    // Hazard and credit view seen by the issue check
    always_comb begin
`ifdef RISCV_EXU_DISPATCH_BYPASS_EN
        lock_view = locked_q & ~clr_mask;
        credit_ok = (cnt_q[unit_idx] < CNT_W'(UNIT_DEPTH)) || bus.unit_done[unit_idx];
`else
        lock_view = locked_q;
        credit_ok = (cnt_q[unit_idx] < CNT_W'(UNIT_DEPTH));
`endif
        // locked_q[0] is never set, so x0 sources/destinations cannot stall
        hazard = (bus.in_rs1_used && lock_view[bus.in_rs1]) ||
                 (bus.in_rs2_used && lock_view[bus.in_rs2]) ||
                 (bus.in_rd_used  && (bus.in_rd != 5'd0) && lock_view[bus.in_rd]);
        issue_ok = !reset && bus.in_vld && (state_q == ST_RUN) && !bus.flush &&
                   bus.unit_ready[unit_idx] && credit_ok && !hazard;
    end

    always_comb begin
        all_idle = 1'b1;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (cnt_q[k] != '0) all_idle = 1'b0;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.flush) state_d = ST_DRAIN;
            ST_DRAIN: if (!bus.flush && all_idle) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM / issue outputs; hold is forced high while in reset
    always_comb begin
        bus.issue_vld = '0;
        bus.hold      = bus.in_vld;
        if (reset) begin
            bus.hold = 1'b1;
        end else if (issue_ok) begin
            bus.issue_vld[unit_idx] = 1'b1;
            bus.hold                = 1'b0;
        end
        bus.busy            = !all_idle;
        bus.register_locked = locked_q;
    end

    // Scoreboard: set beats a same-cycle clear; wiped when the drain completes
    always_comb begin
        set_mask = '0;
        if (issue_ok && bus.in_rd_used && (bus.in_rd != 5'd0)) set_mask[bus.in_rd] = 1'b1;
        locked_d = (locked_q & ~clr_mask) | set_mask;
        if ((state_q == ST_DRAIN) && (state_d == ST_RUN)) locked_d = '0;
        locked_d[0] = 1'b0;
    end

    // Per-unit outstanding counters; done at zero is ignored
    always_comb begin
        for (int k = 0; k < NUM_UNITS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (bus.issue_vld[k] && !(bus.unit_done[k] && (cnt_q[k] != '0))) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else if (!bus.issue_vld[k] && bus.unit_done[k] && (cnt_q[k] != '0)) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            locked_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
